// File: rtl/rvdiv_seq.sv
// rvdiv_seq -- iterative radix-2 divide/remainder sequencer (RV32M DIV/DIVU/REM/REMU)
//
// Sits in the Execute stage. A divide-class op present in E is captured on the
// IDLE edge, then resolved by a restoring shift/subtract loop that produces one
// quotient bit per cycle (MSB first). DivBusy stalls F/D/E while the loop runs.
// The result is presented on DivResultE together with a one-cycle DivDoneE.
// Divide-by-zero and signed overflow skip the loop and finish in one cycle.
//
// Ports:
//   clk         clock, all state updates on posedge
//   reset       synchronous, active-high
//   DivStartE   E stage holds a valid divide-class op
//   DivOpE      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   SrcAE       dividend (post-forwarding)
//   SrcBE       divisor  (post-forwarding)
//   FlushE      kill the E-stage op; aborts an in-flight divide
//   DivBusy     stall request to the hazard unit (combinational)
//   DivDoneE    result valid, one-cycle pulse
//   DivResultE  quotient or remainder, held until the next completion or reset
//
// Parameters:
//   XLEN   operand/result width
//   CNT_W  iteration counter width, 2**CNT_W must exceed XLEN

module rvdiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            DivStartE,
  input  logic [1:0]      DivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            DivBusy,
  output logic            DivDoneE,
  output logic [XLEN-1:0] DivResultE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Datapath registers of the iteration loop.
  logic [XLEN-1:0]  rem_q;      // partial remainder R (always < |B|, fits XLEN bits)
  logic [XLEN-1:0]  quo_q;      // shifts |A| out at the top, quotient bits in at the bottom
  logic [XLEN-1:0]  divisor_q;  // |B|
  logic             rem_op_q;   // 1: REM/REMU, 0: DIV/DIVU
  logic             sign_q;     // negate quotient at the end
  logic             sign_r;     // negate remainder at the end

  // ---------------------------------------------------------------------------
  // Operand decode in IDLE
  // ---------------------------------------------------------------------------
  logic            op_signed;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            signed_ovf;
  logic            start_ok;
  logic [XLEN-1:0] special_res;

  assign op_signed  = ~DivOpE[0];
  assign op_rem     = DivOpE[1];
  assign a_neg      = op_signed & SrcAE[XLEN-1];
  assign b_neg      = op_signed & SrcBE[XLEN-1];
  assign abs_a      = a_neg ? -SrcAE : SrcAE;
  assign abs_b      = b_neg ? -SrcBE : SrcBE;
  assign div_zero   = (SrcBE == '0);
  assign signed_ovf = op_signed & (SrcAE == INT_MIN) & (SrcBE == '1);
  assign start_ok   = DivStartE & ~FlushE;

  // Overflow: quotient is the dividend itself (INT_MIN), remainder is zero.
  // Divide-by-zero: quotient all ones, remainder is the dividend.
  assign special_res = div_zero ? (op_rem ? SrcAE : '1)
                                : (op_rem ? '0    : SrcAE);

  // ---------------------------------------------------------------------------
  // One restoring iteration: {R,Q} <<= 1; if R >= |B| then R -= |B|, Q[0] = 1
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   rem_shift;   // one extra bit holds the carry out of the shift
  logic            rem_ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] calc_res;
  logic            last_iter;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor_q});
  assign rem_nxt   = rem_ge ? XLEN'(rem_shift - {1'b0, divisor_q}) : rem_shift[XLEN-1:0];
  assign quo_nxt   = {quo_q[XLEN-2:0], rem_ge};
  assign last_iter = (cnt == CNT_W'(XLEN - 1));

  // Sign fix-up is applied to the values the final iteration is producing, so
  // the result register is loaded on the same edge that enters DONE.
  assign calc_res = rem_op_q ? (sign_r ? -rem_nxt : rem_nxt)
                             : (sign_q ? -quo_nxt : quo_nxt);

  // ---------------------------------------------------------------------------
  // Control: state, counter, result register
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the block order never matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      DivResultE <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            cnt <= '0;
            if (div_zero || signed_ovf) begin
              state      <= S_DONE;
              DivResultE <= special_res;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (FlushE) begin
            // Abandon the op; the previous result stays visible.
            state <= S_IDLE;
            cnt   <= '0;
          end else if (last_iter) begin
            state      <= S_DONE;
            cnt        <= '0;
            DivResultE <= calc_res;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // DONE always returns to IDLE: DivStartE from the op still in E is
        // ignored here, and a flush only makes the consumer drop the pulse.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: loaded on the IDLE->CALC edge, shifted every CALC cycle
  // ---------------------------------------------------------------------------
  // NOTE: the loop registers carry no reset; they are always loaded on the
  // start edge before being read, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start_ok && !div_zero && !signed_ovf) begin
      rem_q     <= '0;
      quo_q     <= abs_a;
      divisor_q <= abs_b;
      rem_op_q  <= op_rem;
      sign_q    <= a_neg ^ b_neg;
      sign_r    <= a_neg;
    end else if (state == S_CALC) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  // Busy drops in DONE so the pipeline advances on the edge that closes DONE.
  assign DivBusy  = ~reset & (((state == S_IDLE) & start_ok) | (state == S_CALC));
  assign DivDoneE = (state == S_DONE);

endmodule

// File: tb/tb_rvdiv_seq.sv
// tb_rvdiv_seq -- self-checking bench for rvdiv_seq.
// Directed cases cover reset, latency, signed/unsigned results, special cases,
// flush and back-to-back ops; a randomized phase compares against an
// arithmetic reference model of the RV32M divide rules.

module tb_rvdiv_seq;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic            clk = 1'b0;
  logic            reset;
  logic            DivStartE;
  logic [1:0]      DivOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            DivBusy;
  logic            DivDoneE;
  logic [XLEN-1:0] DivResultE;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] last_res;  // value DivResultE should be holding

  always #5 clk = ~clk;

  rvdiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .DivStartE  (DivStartE),
    .DivOpE     (DivOpE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .FlushE     (FlushE),
    .DivBusy    (DivBusy),
    .DivDoneE   (DivDoneE),
    .DivResultE (DivResultE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics written directly as arithmetic: truncating signed division,
  // remainder follows the dividend, plus the two architected special cases.
  function automatic logic [31:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    if (b == 32'd0)
      return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return op[1] ? 32'd0 : a;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Runs one op with cycle 0 = first cycle DivStartE is presented.
  // flush_at >= 0 raises FlushE in that cycle. hold_after leaves DivStartE high
  // and returns in the DONE cycle so the caller can present the next op at once.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input bit hold_after);
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic [31:0] got      = '0;
    logic [31:0] exp;
    bit          special;

    special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    exp     = ref_result(op, a, b);

    @(posedge clk); #1;
    DivStartE = 1'b1;
    FlushE    = (flush_at == 0);
    DivOpE    = op;
    SrcAE     = a;
    SrcBE     = b;

    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (DivBusy) busy_cnt++;
      if (DivDoneE) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          got      = DivResultE;
        end
      end
      if (done_cyc >= 0 && hold_after) break;
      if (done_cyc >= 0 && cyc == done_cyc + 2) break;
      @(posedge clk); #1;
      FlushE = (cyc + 1 == flush_at);
      if (done_cyc >= 0 || (flush_at >= 0 && cyc >= flush_at)) begin
        DivStartE = 1'b0;
      end else begin
        // Forwarded operands wander after the sampling edge; must be ignored.
        SrcAE = $urandom;
        SrcBE = $urandom;
      end
    end

    if (flush_at >= 0) begin
      check({tag, " busy_cycles"}, busy_cnt, flush_at + 1);
      check({tag, " done_count"}, done_cnt, 0);
      check({tag, " result_held"}, DivResultE, last_res);
    end else begin
      check({tag, " done_cycle"}, done_cyc, special ? 1 : XLEN + 1);
      check({tag, " busy_cycles"}, busy_cnt, special ? 1 : XLEN + 1);
      check({tag, " result"}, got, exp);
      check({tag, " done_count"}, done_cnt, 1);
      if (!hold_after) check({tag, " result_held"}, DivResultE, exp);
      last_res = exp;
    end
  endtask

  initial begin
    int dones;

    reset     = 1'b1;
    DivStartE = 1'b0;
    FlushE    = 1'b0;
    DivOpE    = 2'b00;
    SrcAE     = '0;
    SrcBE     = '0;
    last_res  = '0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", DivBusy, 0);
    check("reset done", DivDoneE, 0);
    check("reset result", DivResultE, 0);

    // T2: basic unsigned latency and results
    run_op("T2 DIVU 100/7", OP_DIVU, 32'd100, 32'd7, -1, 1'b0);
    run_op("T2 REMU 100/7", OP_REMU, 32'd100, 32'd7, -1, 1'b0);
    check("T2 REMU value", last_res, 32'd2);

    // T1: reset while in CALC (cycles 1..5 are CALC, reset raised in cycle 6)
    @(posedge clk); #1;
    DivStartE = 1'b1; DivOpE = OP_DIVU; SrcAE = 32'd100; SrcBE = 32'd7;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("T1 busy during reset", DivBusy, 0);
    @(posedge clk); #1;
    reset = 1'b0; DivStartE = 1'b0;
    @(negedge clk);
    check("T1 busy after reset", DivBusy, 0);
    check("T1 done after reset", DivDoneE, 0);
    check("T1 result after reset", DivResultE, 0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (DivDoneE) dones++;
    end
    check("T1 no done after abort", dones, 0);
    last_res = '0;

    // T3: signed results
    run_op("T3 DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    check("T3 DIV value", last_res, 32'hFFFF_FFFD);
    run_op("T3 REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    check("T3 REM value", last_res, 32'hFFFF_FFFF);
    run_op("T3 DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, 1'b0);

    // T4: special cases
    run_op("T4 DIVU 5/0", OP_DIVU, 32'd5, 32'd0, -1, 1'b0);
    run_op("T4 REMU 5/0", OP_REMU, 32'd5, 32'd0, -1, 1'b0);
    run_op("T4 DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    check("T4 DIV ovf value", last_res, 32'h8000_0000);
    run_op("T4 REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);

    // FlushE together with DivStartE in IDLE: no start
    @(posedge clk); #1;
    DivStartE = 1'b1; FlushE = 1'b1; DivOpE = OP_DIVU; SrcAE = 32'd9; SrcBE = 32'd0;
    @(negedge clk);
    check("flush+start busy", DivBusy, 0);
    @(posedge clk); #1;
    DivStartE = 1'b0; FlushE = 1'b0;
    @(negedge clk);
    check("flush+start done", DivDoneE, 0);
    check("flush+start result", DivResultE, last_res);

    // T5: flush in CALC cycle 10, then a clean op
    run_op("T5 flushed DIVU", OP_DIVU, 32'd50, 32'd3, 10, 1'b0);
    run_op("T5 DIVU 9/3", OP_DIVU, 32'd9, 32'd3, -1, 1'b0);

    // T6: DivStartE held through DONE, next op presented in the following IDLE cycle
    run_op("T6 first DIVU", OP_DIVU, 32'd100, 32'd7, -1, 1'b1);
    run_op("T6 DIVU 8/2", OP_DIVU, 32'd8, 32'd2, -1, 1'b0);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          kind;
      op   = 2'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      case (kind)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
        3: b = $urandom_range(1, 7) | (b & 32'h8000_0000);
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
